// File: rtl/ysyx_220053_idu_pipe.sv
// ysyx_220053_idu_pipe
//
// Registered RV64I decode stage placed between fetch and execute.
// Each instruction is decoded combinationally as it is accepted. The
// decoded control bundle is stored in a two-entry buffer: a main entry
// and a skid entry. An ebreak or an illegal word puts the stage into a
// sticky halt.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid       fetch presents an instruction
//   in_ready       stage accepts this cycle (registered state only)
//   in_inst        32-bit instruction word
//   in_pc          PC of in_inst
//   out_valid      decoded bundle valid
//   out_ready      execute accepts the bundle
//   out_pc         PC of the decoded instruction
//   rd, rs1, rs2   register indices
//   wen            register-file write enable
//   ALUSrcB        1 = imm feeds ALU B, 0 = rs2 data feeds ALU B
//   imm            sign-extended immediate
//   out_illegal    instruction not decodable
//   out_ebreak     instruction is ebreak
//   halted         sticky halt state
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | accepting instructions while the skid entry is empty
// HALT  | ebreak/illegal accepted; buffered entries drain, no new input
//
// XLEN must be greater than 32, because the 32-bit immediate is
// sign-extended to XLEN.

module ysyx_220053_idu_pipe #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic              wen,
    output logic              ALUSrcB,
    output logic [XLEN-1:0]   imm,
    output logic              out_illegal,
    output logic              out_ebreak,
    output logic              halted
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              wen;
        logic              alu_src_b;
        logic [XLEN-1:0]   imm;
        logic              illegal;
        logic              ebreak;
    } entry_t;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    state_t state, state_nxt;
    entry_t main_q, skid_q, dec;
    logic   main_valid, skid_valid;
    logic   accept, consume, halt_trig;

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic        wen_raw;

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    assign opcode = in_inst[6:0];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec           = '0;
        imm32         = '0;
        wen_raw       = 1'b0;
        dec.pc        = in_pc;
        dec.rd        = in_inst[11:7];
        dec.rs1       = in_inst[19:15];
        dec.rs2       = in_inst[24:20];

        if (in_inst == EBREAK_WORD) begin
            dec.ebreak = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
                    wen_raw       = 1'b1;
                    dec.alu_src_b = 1'b1;
                    imm32         = imm_i;
                end
                OPC_OP, OPC_OP_32: begin
                    wen_raw = 1'b1;
                end
                OPC_STORE: begin
                    dec.alu_src_b = 1'b1;
                    imm32         = imm_s;
                end
                OPC_BRANCH: begin
                    imm32 = imm_b;
                end
                OPC_LUI: begin
                    wen_raw       = 1'b1;
                    dec.alu_src_b = 1'b1;
                    dec.rs1       = '0;
                    imm32         = imm_u;
                end
                OPC_AUIPC: begin
                    wen_raw       = 1'b1;
                    dec.alu_src_b = 1'b1;
                    imm32         = imm_u;
                end
                OPC_JAL: begin
                    wen_raw       = 1'b1;
                    dec.alu_src_b = 1'b1;
                    imm32         = imm_j;
                end
                default: begin
                    dec.illegal = 1'b1;
                end
            endcase
        end

        dec.imm = {{(XLEN-32){imm32[31]}}, imm32};
        // Writes to x0 are dropped here, so execute never has to filter them.
        dec.wen = wen_raw && (dec.rd != '0);
    end

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    // in_ready looks only at registered state, so there is no
    // combinational path from out_ready back to fetch.
    assign in_ready  = (state == ST_RUN) && !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign consume   = main_valid && out_ready;
    assign halt_trig = accept && (dec.illegal || dec.ebreak);

    // ---------------------------------------------------------------
    // Halt FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (halt_trig) state_nxt = ST_HALT;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign halted = (state == ST_HALT);

    // ---------------------------------------------------------------
    // Two-entry buffer
    // ---------------------------------------------------------------
    // Accept and skid_valid cannot both be true (in_ready needs an empty
    // skid). So when the main entry is consumed, it is refilled from
    // exactly one source: the skid entry or the incoming instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (consume) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end else begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end
        end
    end

    assign out_pc      = main_q.pc;
    assign rd          = main_q.rd;
    assign rs1         = main_q.rs1;
    assign rs2         = main_q.rs2;
    assign wen         = main_q.wen;
    assign ALUSrcB     = main_q.alu_src_b;
    assign imm         = main_q.imm;
    assign out_illegal = main_q.illegal;
    assign out_ebreak  = main_q.ebreak;

endmodule

// File: tb/tb_ysyx_220053_idu_pipe.sv
// Testbench for ysyx_220053_idu_pipe: directed scenarios plus random
// traffic checked against a queue-based reference of the stage.
module tb_ysyx_220053_idu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  rd, rs1, rs2;
    logic        wen, ALUSrcB, out_illegal, out_ebreak, halted;
    logic [63:0] imm;

    ysyx_220053_idu_pipe #(.XLEN(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2),
        .wen(wen), .ALUSrcB(ALUSrcB), .imm(imm),
        .out_illegal(out_illegal), .out_ebreak(out_ebreak),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic        wen, srcb, ill, ebr;
        logic [63:0] imm;
    } bundle_t;

    int checks = 0;
    int errors = 0;

    bundle_t     q[$];       // instructions the stage holds, oldest first
    bit          m_halt;
    logic [63:0] next_pc;
    int          n_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [63:0] pc);
        bundle_t b;
        logic [31:0] val;
        b.pc = pc; b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
        b.wen = 0; b.srcb = 0; b.ill = 0; b.ebr = 0; b.imm = 64'd0;
        if (i == 32'h0010_0073) begin
            b.ebr = 1;
        end else begin
            case (i[6:0])
                7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
                    b.wen = 1; b.srcb = 1;
                    val = 32'($signed(i[31:20]));
                    b.imm = sx(val);
                end
                7'b0110011, 7'b0111011: b.wen = 1;
                7'b0100011: begin
                    b.srcb = 1;
                    val = 32'($signed({i[31:25], i[11:7]}));
                    b.imm = sx(val);
                end
                7'b1100011: begin
                    val = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                    b.imm = sx(val);
                end
                7'b0110111: begin
                    b.wen = 1; b.srcb = 1; b.rs1 = 5'd0;
                    b.imm = sx({i[31:12], 12'd0});
                end
                7'b0010111: begin
                    b.wen = 1; b.srcb = 1;
                    b.imm = sx({i[31:12], 12'd0});
                end
                7'b1101111: begin
                    b.wen = 1; b.srcb = 1;
                    val = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
                    b.imm = sx(val);
                end
                default: b.ill = 1;
            endcase
        end
        if (b.rd == 5'd0) b.wen = 0;
        return b;
    endfunction

    // One clock cycle: drive after the falling edge, check, then update
    // the reference on the rising edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic ordy);
        bundle_t b, dropped;
        bit acc, cons;
        in_valid = v; in_inst = inst; in_pc = next_pc; out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!m_halt && q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("halted", 64'(halted), 64'(m_halt));
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("rd", 64'(rd), 64'(q[0].rd));
            chk("rs1", 64'(rs1), 64'(q[0].rs1));
            chk("rs2", 64'(rs2), 64'(q[0].rs2));
            chk("wen", 64'(wen), 64'(q[0].wen));
            chk("ALUSrcB", 64'(ALUSrcB), 64'(q[0].srcb));
            chk("imm", imm, q[0].imm);
            chk("illegal", 64'(out_illegal), 64'(q[0].ill));
            chk("ebreak", 64'(out_ebreak), 64'(q[0].ebr));
        end
        acc  = v && !m_halt && q.size() < 2;
        cons = q.size() > 0 && ordy;
        b = ref_decode(inst, next_pc);
        @(posedge clk);
        if (cons) dropped = q.pop_front();
        if (acc) begin
            q.push_back(b);
            if (b.ill || b.ebr) m_halt = 1;
            next_pc = next_pc + 64'd4;
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_halted"}, 64'(halted), 64'd0);
        chk({tag, "_bundle"}, {out_pc ^ imm, 59'd0, rd | rs1 | rs2} , 64'd0);
        chk({tag, "_flags"}, 64'({wen, ALUSrcB, out_illegal, out_ebreak}), 64'd0);
    endtask

    task automatic do_reset();
        in_valid = 0;
        #2 rst = 1;
        #1 chk_zero("rst");
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        q.delete();
        m_halt = 0;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0]  ops [10] = '{7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011,
                                  7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                                  7'b0010111, 7'b1101111};
        logic [31:0] r = $urandom;
        int sel = $urandom_range(0, 99);
        if (sel < 2) return 32'h0010_0073;
        if (sel < 5) return r;
        if (sel < 10) return {r[31:7], 7'b1100111};
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
        next_pc = 64'h8000_0000; m_halt = 0; n_acc = 0;
        #3 chk_zero("por");
        @(negedge clk);
        rst = 0;

        // basic decodes
        step(1, 32'h0050_0093, 1);
        chk("addi_imm", imm, 64'h5);
        chk("addi_rd", 64'(rd), 64'd1);
        chk("addi_wen", 64'(wen), 64'd1);
        chk("addi_pc", out_pc, 64'h8000_0000);
        step(1, 32'hfff0_8113, 1);
        chk("addi_neg_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_neg_rs1", 64'(rs1), 64'd1);
        step(1, 32'h0020_b423, 1);
        chk("sd_imm", imm, 64'h8);
        chk("sd_wen", 64'(wen), 64'd0);
        chk("sd_rs2", 64'(rs2), 64'd2);
        step(1, 32'h0000_0013, 1);
        chk("nop_wen", 64'(wen), 64'd0);
        step(0, 32'h0, 1);

        // backpressure: four instructions, execute stalled for 3 cycles
        begin
            int start = n_acc;
            int cyc = 0;
            while (n_acc < start + 4 && cyc < 20) begin
                step(1, 32'h0010_0093 + ((n_acc - start) << 7), cyc >= 3);
                if (cyc == 1) chk("bp_in_ready", 64'(in_ready), 64'd0);
                cyc++;
            end
            chk("bp_all_accepted", 64'(n_acc - start), 64'd4);
            repeat (4) step(0, 32'h0, 1);
            chk("bp_drained", 64'(out_valid), 64'd0);
        end

        // ebreak halts; following addi is never accepted
        step(1, 32'h0010_0073, 1);
        chk("ebr_flag", 64'(out_ebreak), 64'd1);
        chk("ebr_halted", 64'(halted), 64'd1);
        repeat (3) step(1, 32'h0050_0093, 1);
        chk("ebr_no_more", 64'(out_valid), 64'd0);
        do_reset();

        // illegal word halts
        step(1, 32'hFFFF_FFFF, 1);
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_halted", 64'(halted), 64'd1);
        step(0, 32'h0, 1);
        do_reset();

        // reset with two buffered entries while halted
        step(1, 32'h0050_0093, 0);
        step(1, 32'h0010_0073, 0);
        chk("rst2_halted", 64'(halted), 64'd1);
        chk("rst2_in_ready", 64'(in_ready), 64'd0);
        do_reset();
        repeat (3) step(0, 32'h0, 1);
        step(1, 32'hfff0_8113, 1);
        step(0, 32'h0, 1);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ((m_halt && q.size() == 0 && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 499) == 0)
                do_reset();
            else
                step($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
